// File: rtl/notch_sequencer.sv
// notch_sequencer
//   Sample-rate controller for the adaptive notch filter instance. A programmable
//   divider produces one sample tick every CLK_DIV cycles. On each tick the ADC word
//   is either latched into the filter input with a one-cycle sample strobe, or, in
//   bypass, sent straight to the result register. A filter result is accepted only
//   on the rising edge of filt_done while waiting. A watchdog abandons a hung filter.
//
// Ports
//   clk, reset          system clock (rising edge), asynchronous active-high reset
//   enable              run the divider; low holds it at zero (no ticks)
//   bypass              route adc_data straight to dout, sampled on the tick
//   clr_err             synchronous clear of the sticky error flags
//   adc_data            ADC sample word
//   filt_data_out       filter result word
//   filt_done           filter completion, level or pulse (edge-detected here)
//   filt_data_in        registered word to the filter data input
//   filt_sample         one-cycle strobe to the filter sample trigger
//   dout, dout_valid    last result (held) and its one-cycle update strobe
//   busy                a filter transaction is in flight
//   overrun             sticky: tick arrived while busy, that sample was dropped
//   timeout_err         sticky: filter did not finish within TIMEOUT wait cycles
//   sample_cnt          number of dout_valid strobes, wraps silently

module notch_sequencer #(
    parameter int unsigned DATA_SIZE = 25,
    parameter int unsigned CLK_DIV   = 2500,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 bypass,
    input  logic                 clr_err,
    input  logic [DATA_SIZE-2:0] adc_data,
    input  logic [DATA_SIZE-2:0] filt_data_out,
    input  logic                 filt_done,
    output logic [DATA_SIZE-2:0] filt_data_in,
    output logic                 filt_sample,
    output logic [DATA_SIZE-2:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     sample_cnt
);

    localparam int unsigned DW     = DATA_SIZE - 1;
    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTrig,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              done_prev_q;
    logic [DW-1:0]     filt_data_in_q, filt_data_in_d;
    logic              filt_sample_q, filt_sample_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overrun_q, overrun_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;

    logic tick;
    logic done_rise;

    assign tick      = enable & (div_cnt_q == DIV_LAST);
    assign done_rise = filt_done & ~done_prev_q;

    // Divider: free-runs 0..CLK_DIV-1 while enabled, parked at zero otherwise so
    // a re-enable always starts a full period.
    always_comb begin
        div_cnt_d = '0;
        if (enable) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        filt_data_in_d = filt_data_in_q;
        filt_sample_d  = 1'b0;
        dout_d         = dout_q;
        dout_valid_d   = 1'b0;
        sample_cnt_d   = sample_cnt_q;
        // Clear first so that a same-cycle set below takes priority.
        overrun_d      = overrun_q & ~clr_err;
        timeout_err_d  = timeout_err_q & ~clr_err;

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (bypass) begin
                        dout_d       = adc_data;
                        dout_valid_d = 1'b1;
                        sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    end else begin
                        filt_data_in_d = adc_data;
                        filt_sample_d  = 1'b1;
                        state_d        = StTrig;
                    end
                end
            end
            StTrig: begin
                // A done edge during the trigger cycle is stale and ignored.
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // Completion beats a coincident watchdog expiry.
                if (done_rise) begin
                    dout_d       = filt_data_out;
                    dout_valid_d = 1'b1;
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    state_d      = StIdle;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A tick that finds a transaction in flight is dropped and flagged.
        if (tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            div_cnt_q      <= '0;
            wait_cnt_q     <= '0;
            done_prev_q    <= 1'b0;
            filt_data_in_q <= '0;
            filt_sample_q  <= 1'b0;
            dout_q         <= '0;
            dout_valid_q   <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            sample_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            div_cnt_q      <= div_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            done_prev_q    <= filt_done;
            filt_data_in_q <= filt_data_in_d;
            filt_sample_q  <= filt_sample_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
            sample_cnt_q   <= sample_cnt_d;
        end
    end

    assign filt_data_in = filt_data_in_q;
    assign filt_sample  = filt_sample_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign busy         = (state_q != StIdle);
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;
    assign sample_cnt   = sample_cnt_q;

endmodule
